instr_assembler: RTL and testbench

Sequential instruction-word builder that runs the control decoder's opcode/funct mapping in reverse. It accepts symbolic micro-op requests (ADD, SUB, ADDI, BEQ plus register/immediate fields) over a valid/ready handshake. It encodes each request into a 32-bit MIPS word and writes the words to consecutive instruction-memory addresses. It sits between the test/boot loader and the instruction memory, so programs are produced with exactly the opcode/funct values the decoder expects.

---
 rtl/instr_assembler.sv | 97 +++++++++
 tb/tb_instr_assembler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_assembler.sv
// Builds MIPS instruction words from symbolic ADD/SUB/ADDI/BEQ requests and
// writes them to consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_assembler #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [ADDR_W-1:0] req_target,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;
    logic [15:0]       beq_off;
    logic [31:0]       word;

    assign req_ready = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = req_valid && (state == RUN);

    // The branch offset is bounded by ADDR_W+1 bits, so 16-bit modular
    // arithmetic already yields its sign-extended value.
    always_comb begin
        beq_off = 16'(req_target) - 16'(wr_ptr) - 16'd1;
        word    = '0;
        case (req_op)
            2'd0:    word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
            2'd1:    word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
            2'd2:    word = {6'b001000, req_rs, req_rt, req_imm};
            default: word = {6'b000100, req_rs, req_rt, beq_off};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= BASE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        wr_ptr <= BASE;
                        count  <= '0;
                        full   <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= word;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        count     <= count + (ADDR_W + 1)'(1);
                        if (req_last) begin
                            state <= DONE;
                        end else if (wr_ptr == LAST_ADDR) begin
                            state <= DONE;
                            full  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed table, corner sequences
// on a 6-bit and a 2-bit address instance, and randomized programs vs a model.
module tb_instr_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ADDR_W = 6 instance
    logic        rst, start, req_valid, req_ready, req_last;
    logic [1:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic [5:0]  req_target;
    logic        mem_we, done, full;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;

    // ADDR_W = 2 instance (shares op/register/immediate fields)
    logic        rst2, start2, valid2, ready2, last2;
    logic [1:0]  target2;
    logic        we2, done2, full2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    instr_assembler #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .full(full)
    );

    instr_assembler #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .req_valid(valid2), .req_ready(ready2),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm(req_imm), .req_target(target2), .req_last(last2),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .count(count2), .done(done2), .full(full2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    // Reference encoding from field arithmetic; BEQ offset is the true
    // signed distance target-(addr+1) reduced modulo 2^16.
    function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt,
                                             input int rd, input int imm,
                                             input int target, input int addr);
        int w;
        case (op)
            0:       w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 32;
            1:       w = rs * (2**21) + rt * (2**16) + rd * (2**11) + 34;
            2:       w = 8 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
            default: w = 4 * (2**26) + rs * (2**21) + rt * (2**16) + ((target - addr - 1) & 'hFFFF);
        endcase
        return 32'(w);
    endfunction

    task automatic set_req(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [15:0] im,
                           input logic [5:0] tg, input logic lst);
        req_op = op; req_rs = a; req_rt = b; req_rd = c;
        req_imm = im; req_target = tg; req_last = lst;
    endtask

    typedef struct {
        bit          first;
        logic [1:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  target;
        bit          last;
        int          exp_addr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ptr;
        int len;
        logic [31:0] exp_w;

        vecs[0] = '{1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 6'd0, 1'b0, 0, 32'h00221820};
        vecs[1] = '{1'b0, 2'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 6'd0, 1'b1, 1, 32'h00221822};
        vecs[2] = '{1'b1, 2'd2, 5'd0, 5'd1, 5'd7, 16'h0005, 6'd9, 1'b0, 0, 32'h20010005};
        vecs[3] = '{1'b0, 2'd2, 5'd0, 5'd2, 5'd9, 16'hFFFF, 6'd0, 1'b1, 1, 32'h2002FFFF};
        vecs[4] = '{1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 6'd0, 1'b0, 0, 32'h00221820};
        vecs[5] = '{1'b0, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 6'd0, 1'b0, 1, 32'h00221820};
        vecs[6] = '{1'b0, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 6'd0, 1'b0, 2, 32'h00221820};
        vecs[7] = '{1'b0, 2'd3, 5'd1, 5'd2, 5'd5, 16'h1234, 6'd0, 1'b1, 3, 32'h1022FFFC};
        vecs[8] = '{1'b1, 2'd3, 5'd1, 5'd2, 5'd0, 16'h0000, 6'd5, 1'b1, 0, 32'h10220004};

        rst = 1; start = 0; req_valid = 0;
        rst2 = 1; start2 = 0; valid2 = 0; last2 = 0; target2 = 0;
        set_req(2'd0, 5'd0, 5'd0, 5'd0, 16'h0, 6'd0, 1'b0);
        repeat (2) @(negedge clk);
        cmp("rst_ready", 32'(req_ready), 0);
        cmp("rst_we", 32'(mem_we), 0);
        cmp("rst_addr", 32'(mem_addr), 0);
        cmp("rst_wdata", mem_wdata, 0);
        cmp("rst_count", 32'(count), 0);
        cmp("rst_done", 32'(done), 0);
        cmp("rst_full", 32'(full), 0);
        cmp("rst2_ready", 32'(ready2), 0);
        cmp("rst2_count", 32'(count2), 0);
        rst = 0; rst2 = 0;

        // Requests in IDLE are ignored
        set_req(2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 6'd0, 1'b0);
        req_valid = 1;
        repeat (3) begin
            @(negedge clk);
            cmp("idle_we", 32'(mem_we), 0);
            cmp("idle_count", 32'(count), 0);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        cmp("start_ready", 32'(req_ready), 1);
        cmp("start_we", 32'(mem_we), 0);
        set_req(2'd2, 5'd0, 5'd4, 5'd0, 16'h0010, 6'd0, 1'b1);
        @(negedge clk);
        cmp("first_we", 32'(mem_we), 1);
        cmp("first_addr", 32'(mem_addr), 0);
        cmp("first_data", mem_wdata, 32'h20040010);
        cmp("first_done", 32'(done), 1);
        req_valid = 0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].first) begin
                req_valid = 0;
                start = 1;
                @(negedge clk);
                start = 0;
            end
            set_req(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm,
                    vecs[i].target, vecs[i].last);
            req_valid = 1;
            @(negedge clk);
            cmp($sformatf("vec%0d_we", i), 32'(mem_we), 1);
            cmp($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            cmp($sformatf("vec%0d_data", i), mem_wdata, vecs[i].exp_word);
            cmp($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_addr + 1));
            if (vecs[i].last) begin
                cmp($sformatf("vec%0d_done", i), 32'(done), 1);
                cmp($sformatf("vec%0d_full", i), 32'(full), 0);
                cmp($sformatf("vec%0d_ready", i), 32'(req_ready), 0);
                req_valid = 0;
            end
        end

        // Requests in DONE are ignored
        req_valid = 1;
        repeat (2) begin
            @(negedge clk);
            cmp("done_ign_we", 32'(mem_we), 0);
            cmp("done_ign_count", 32'(count), 1);
            cmp("done_ign_done", 32'(done), 1);
        end
        req_valid = 0;

        // start while RUN is ignored
        start = 1;
        @(negedge clk);
        set_req(2'd0, 5'd5, 5'd6, 5'd7, 16'h0, 6'd0, 1'b0);
        req_valid = 1;
        @(negedge clk);
        start = 0;
        cmp("runstart_addr0", 32'(mem_addr), 0);
        set_req(2'd1, 5'd5, 5'd6, 5'd7, 16'h0, 6'd0, 1'b1);
        @(negedge clk);
        cmp("runstart_addr1", 32'(mem_addr), 1);
        cmp("runstart_data1", mem_wdata, ref_enc(1, 5, 6, 7, 0, 0, 1));
        cmp("runstart_count", 32'(count), 2);
        req_valid = 0;

        // Reset mid-program
        start = 1;
        @(negedge clk);
        start = 0;
        set_req(2'd2, 5'd3, 5'd4, 5'd0, 16'h7777, 6'd0, 1'b0);
        req_valid = 1;
        repeat (2) @(negedge clk);
        cmp("midrst_pre_count", 32'(count), 2);
        req_valid = 0;
        rst = 1;
        @(negedge clk);
        cmp("midrst_we", 32'(mem_we), 0);
        cmp("midrst_addr", 32'(mem_addr), 0);
        cmp("midrst_wdata", mem_wdata, 0);
        cmp("midrst_count", 32'(count), 0);
        cmp("midrst_done", 32'(done), 0);
        cmp("midrst_ready", 32'(req_ready), 0);
        start = 1;
        @(negedge clk);
        rst = 0; start = 0;
        cmp("rst_start_ready", 32'(req_ready), 0);
        start = 1;
        @(negedge clk);
        start = 0;
        set_req(2'd2, 5'd1, 5'd9, 5'd0, 16'h00AB, 6'd0, 1'b1);
        req_valid = 1;
        @(negedge clk);
        cmp("restart_addr", 32'(mem_addr), 0);
        cmp("restart_data", mem_wdata, 32'h202900AB);
        cmp("restart_count", 32'(count), 1);
        req_valid = 0;

        // ADDR_W=2: exhaust address space (BEQ at the top address wraps wr_ptr+1)
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        for (int k = 0; k < 4; k++) begin
            set_req((k == 3) ? 2'd3 : 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 6'd0, 1'b0);
            target2 = 2'd0; last2 = 0; valid2 = 1;
            @(negedge clk);
            cmp($sformatf("full_we%0d", k), 32'(we2), 1);
            cmp($sformatf("full_addr%0d", k), 32'(addr2), 32'(k));
            cmp($sformatf("full_data%0d", k), wdata2, ref_enc((k == 3) ? 3 : 0, 1, 2, 3, 0, 0, k));
        end
        cmp("full_done", 32'(done2), 1);
        cmp("full_full", 32'(full2), 1);
        cmp("full_count", 32'(count2), 4);
        cmp("full_ready", 32'(ready2), 0);
        repeat (2) begin
            @(negedge clk);
            cmp("full_5th_we", 32'(we2), 0);
            cmp("full_5th_count", 32'(count2), 4);
            cmp("full_5th_addr", 32'(addr2), 3);
        end
        valid2 = 0;
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        cmp("donestart_ready", 32'(ready2), 1);
        cmp("donestart_done", 32'(done2), 0);
        cmp("donestart_full", 32'(full2), 0);
        cmp("donestart_count", 32'(count2), 0);
        for (int k = 0; k < 4; k++) begin
            set_req((k == 3) ? 2'd3 : 2'd1, 5'd1, 5'd2, 5'd3, 16'h0, 6'd0, 1'b0);
            target2 = 2'd3; last2 = (k == 3); valid2 = 1;
            @(negedge clk);
            cmp($sformatf("lastfit_addr%0d", k), 32'(addr2), 32'(k));
            cmp($sformatf("lastfit_data%0d", k), wdata2, ref_enc((k == 3) ? 3 : 1, 1, 2, 3, 0, 3, k));
        end
        valid2 = 0;
        cmp("lastfit_done", 32'(done2), 1);
        cmp("lastfit_full", 32'(full2), 0);
        cmp("lastfit_count", 32'(count2), 4);

        // Randomized programs against the reference model
        for (int p = 0; p < 10; p++) begin
            req_valid = 0;
            start = 1;
            @(negedge clk);
            start = 0;
            len = (p == 0) ? 80 : int'($urandom_range(1, 80));
            ptr = 0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_valid = 0;
                    @(negedge clk);
                    cmp("rnd_gap_we", 32'(mem_we), 0);
                end
                set_req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        16'($urandom), 6'($urandom), (k == len - 1));
                exp_w = ref_enc(int'(req_op), int'(req_rs), int'(req_rt), int'(req_rd),
                                int'(req_imm), int'(req_target), ptr);
                req_valid = 1;
                @(negedge clk);
                cmp("rnd_we", 32'(mem_we), 1);
                cmp("rnd_addr", 32'(mem_addr), 32'(ptr));
                cmp("rnd_data", mem_wdata, exp_w);
                cmp("rnd_count", 32'(count), 32'(ptr + 1));
                if (k == len - 1 || ptr == 63) begin
                    cmp("rnd_done", 32'(done), 1);
                    cmp("rnd_full", 32'(full), 32'(k != len - 1));
                    cmp("rnd_ready", 32'(req_ready), 0);
                    break;
                end
                ptr++;
            end
            req_valid = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
